// File: rtl/com_seq_sequencer_pkg.sv
// Shared constants for the com_seq vector sequencer: FSM encodings,
// vector field bit positions and the datapath latency ceiling.
package com_seq_sequencer_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRIVE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Table entry layout {A,B,C,expD,expF}
    localparam int VEC_A = 4;
    localparam int VEC_B = 3;
    localparam int VEC_C = 2;
    localparam int VEC_D = 1;
    localparam int VEC_F = 0;

    localparam int LAT_MAX = 7;

endpackage

// File: rtl/com_seq_sequencer_vec_mem.sv
// Vector table: DEPTH x 5 register file, one synchronous write port and
// one asynchronous read port. Contents survive reset on purpose so a
// loaded table can be rerun after a reset.
module com_seq_vec_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [4:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [4:0]    rdata_o
);

    logic [4:0] mem_q [DEPTH];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/com_seq_sequencer.sv
// In-fabric vector sequencer for one com_seq datapath: drives A/B/C from
// a programmable table, waits the datapath latency, checks D/F against the
// expected bits and reports error count, first failing index and pass.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; table writes accepted here only
// DRIVE | load {A,B,C} from table[idx], arm latency counter
// WAIT  | let the datapath settle for LAT cycles
// CHECK | compare {D,F} with expected bits, advance or finish
// DONE  | one-cycle done pulse, pass/err_cnt/fail_idx final
module com_seq_sequencer
    import com_seq_sequencer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int LAT   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [4:0]    cfg_data,
    input  logic [AW:0]   cfg_len,
    input  logic          start,
    output logic          A,
    output logic          B,
    output logic          C,
    input  logic          D,
    input  logic          F,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   err_cnt,
    output logic [AW-1:0] fail_idx
);

    // Out-of-range latency is clamped so the 3-bit wait counter cannot wrap.
    localparam int          LAT_C   = (LAT > LAT_MAX) ? LAT_MAX : ((LAT < 0) ? 0 : LAT);
    localparam logic [2:0]  LAT_W   = 3'(LAT_C);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [2:0]    state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [2:0]    wcnt_q, wcnt_d;
    logic [AW:0]   err_q, err_d;
    logic [AW-1:0] fidx_q, fidx_d;
    logic          pass_q, pass_d;
    logic [2:0]    abc_q, abc_d;

    logic [4:0]    entry;
    logic          mem_we;
    logic          mismatch;
    logic          last_vec;

    // Table writes are only honoured while idle so a running pass sees a
    // stable table.
    assign mem_we = cfg_we && (state_q == ST_IDLE);

    com_seq_vec_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_vec_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (cfg_addr),
        .wdata_i (cfg_data),
        .raddr_i (idx_q),
        .rdata_o (entry)
    );

    assign mismatch = ({D, F} != {entry[VEC_D], entry[VEC_F]});
    assign last_vec = ({1'b0, idx_q} == (len_q - 1'b1));

    // Next-state and datapath updates for the sequencing FSM
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        pass_d  = pass_q;
        abc_d   = abc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d  = (cfg_len > DEPTH_W) ? DEPTH_W : cfg_len;
                    err_d  = '0;
                    fidx_d = '0;
                    idx_d  = '0;
                    pass_d = 1'b0;
                    if (len_d == '0) begin
                        // Empty run: nothing can fail, so pass is known now.
                        pass_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                abc_d   = {entry[VEC_A], entry[VEC_B], entry[VEC_C]};
                wcnt_d  = LAT_W;
                state_d = (LAT_W == 3'd0) ? ST_CHECK : ST_WAIT;
            end
            ST_WAIT: begin
                wcnt_d = wcnt_q - 3'd1;
                if (wcnt_q <= 3'd1) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (err_q == '0) begin
                        fidx_d = idx_q;
                    end
                    if (err_q != DEPTH_W) begin
                        err_d = err_q + 1'b1;
                    end
                end
                if (last_vec) begin
                    // Pass is resolved on entry to DONE so it is valid
                    // alongside the done pulse.
                    pass_d  = (err_d == '0);
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                pass_d  = (err_q == '0);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            wcnt_q  <= '0;
            err_q   <= '0;
            fidx_q  <= '0;
            pass_q  <= 1'b0;
            abc_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            pass_q  <= pass_d;
            abc_q   <= abc_d;
        end
    end

    assign A        = abc_q[2];
    assign B        = abc_q[1];
    assign C        = abc_q[0];
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign fail_idx = fidx_q;

endmodule

// File: tb/tb_com_seq_sequencer.sv
// Bench for com_seq_sequencer: three instances (LAT = 0, 1, 3) share one
// stimulus stream, each with its own loopback stub D=A^B, F=B|C delayed
// LAT cycles. Expected run results go into per-instance queues; a monitor
// per instance pops and compares whenever its done pulse appears.
module tb_com_seq_sequencer;

    typedef struct {
        int len;
        int pass;
        int err;
        int fidx;
        int abc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [4:0] cfg_data = '0;
    logic [3:0] cfg_len = '0;
    logic       start = 1'b0;

    logic       a_v [3];
    logic       b_v [3];
    logic       c_v [3];
    logic       d_v [3];
    logic       f_v [3];
    logic       busy_v [3];
    logic       done_v [3];
    logic       pass_v [3];
    logic [3:0] err_v [3];
    logic [2:0] fidx_v [3];

    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    endtask

    function automatic int q_size(input int g);
        case (g)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop_exp(input int g);
        case (g)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

        com_seq_sequencer #(.DEPTH(8), .AW(3), .LAT(L)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .cfg_we   (cfg_we),
            .cfg_addr (cfg_addr),
            .cfg_data (cfg_data),
            .cfg_len  (cfg_len),
            .start    (start),
            .A        (a_v[g]),
            .B        (b_v[g]),
            .C        (c_v[g]),
            .D        (d_v[g]),
            .F        (f_v[g]),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .pass     (pass_v[g]),
            .err_cnt  (err_v[g]),
            .fail_idx (fidx_v[g])
        );

        if (L == 0) begin : g_comb
            assign d_v[g] = a_v[g] ^ b_v[g];
            assign f_v[g] = b_v[g] | c_v[g];
        end else begin : g_pipe
            logic [L-1:0] dq;
            logic [L-1:0] fq;
            always @(posedge clk) begin
                dq[0] <= a_v[g] ^ b_v[g];
                fq[0] <= b_v[g] | c_v[g];
                for (int k = 1; k < L; k++) begin
                    dq[k] <= dq[k-1];
                    fq[k] <= fq[k-1];
                end
            end
            assign d_v[g] = dq[L-1];
            assign f_v[g] = fq[L-1];
        end

        int   cyc = 0;
        logic busy_p = 1'b0;
        exp_t e;

        // Cycle count runs from the accept edge (busy rises) to done.
        always @(posedge clk) begin
            #1;
            if (busy_v[g] && !busy_p) cyc = 1;
            else if (busy_v[g]) cyc = cyc + 1;
            busy_p = busy_v[g];
            if (done_v[g]) begin
                if (q_size(g) == 0) begin
                    n_total++;
                    $display("FAIL L%0d_unexpected_done: got done=1 expected no done (t=%0t)", L, $time);
                end else begin
                    e = pop_exp(g);
                    chk($sformatf("L%0d_cycles", L), cyc, e.len * (L + 2) + 1);
                    chk($sformatf("L%0d_pass", L), int'(pass_v[g]), e.pass);
                    chk($sformatf("L%0d_err_cnt", L), int'(err_v[g]), e.err);
                    chk($sformatf("L%0d_fail_idx", L), int'(fidx_v[g]), e.fidx);
                    chk($sformatf("L%0d_abc", L), int'({a_v[g], b_v[g], c_v[g]}), e.abc);
                end
            end
        end
    end

    task automatic wr(input logic [2:0] ad, input logic [4:0] dt);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = ad; cfg_data = dt;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic push_exp(input int len, input int ps, input int er, input int fi, input int abc);
        exp_t e;
        e.len = len; e.pass = ps; e.err = er; e.fidx = fi; e.abc = abc;
        q0.push_back(e); q1.push_back(e); q2.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy_v[0] || busy_v[1] || busy_v[2]) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_total++;
            $display("FAIL run_timeout: busy still high after %0d cycles, expected idle", n);
        end
        repeat (2) @(negedge clk);
    endtask

    // Start a run; optionally write a table entry in the same cycle.
    task automatic run(input logic [3:0] len, input bit wen, input logic [2:0] ad,
                       input logic [4:0] dt, input int elen, input int ps,
                       input int er, input int fi, input int abc);
        push_exp(elen, ps, er, fi, abc);
        @(negedge clk);
        cfg_len = len; start = 1'b1;
        cfg_we = wen; cfg_addr = ad; cfg_data = dt;
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        wait_idle();
    endtask

    task automatic chk_zero(input string tag);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_busy%0d", tag, g), int'(busy_v[g]), 0);
            chk($sformatf("%s_done%0d", tag, g), int'(done_v[g]), 0);
            chk($sformatf("%s_pass%0d", tag, g), int'(pass_v[g]), 0);
            chk($sformatf("%s_err%0d", tag, g), int'(err_v[g]), 0);
            chk($sformatf("%s_fidx%0d", tag, g), int'(fidx_v[g]), 0);
            chk($sformatf("%s_abc%0d", tag, g), int'({a_v[g], b_v[g], c_v[g]}), 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // Table: {A,B,C,expD,expF} with D=A^B, F=B|C
        wr(3'd0, 5'b01011);
        wr(3'd1, 5'b11101);
        wr(3'd2, 5'b00000);
        wr(3'd3, 5'b10010);

        // Clean 4-vector run
        run(4'd4, 1'b0, 3'd0, 5'd0, 4, 1, 0, 0, 3'b100);

        // Entry 2 expD corrupted, then entry 3 as well
        wr(3'd2, 5'b00010);
        run(4'd4, 1'b0, 3'd0, 5'd0, 4, 0, 1, 2, 3'b100);
        wr(3'd3, 5'b10000);
        run(4'd4, 1'b0, 3'd0, 5'd0, 4, 0, 2, 2, 3'b100);

        // Empty run: A/B/C keep the last vector
        run(4'd0, 1'b0, 3'd0, 5'd0, 0, 1, 0, 0, 3'b100);

        // Mid-run start/cfg_we must be ignored
        wr(3'd2, 5'b00000);
        wr(3'd3, 5'b10010);
        push_exp(4, 1, 0, 0, 3'b100);
        @(negedge clk);
        cfg_len = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 5'b11111; cfg_len = 4'd1;
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        wait_idle();
        run(4'd4, 1'b0, 3'd0, 5'd0, 4, 1, 0, 0, 3'b100);

        // Reset pulse during vector 1 (WAIT phase of the LAT=1 instance)
        @(negedge clk);
        cfg_len = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run(4'd4, 1'b0, 3'd0, 5'd0, 4, 1, 0, 0, 3'b100);

        // 8 vectors; entry 7 starts wrong and is fixed in the start cycle
        wr(3'd4, 5'b00101);
        wr(3'd5, 5'b11001);
        wr(3'd6, 5'b10111);
        wr(3'd7, 5'b01100);
        run(4'd8, 1'b1, 3'd7, 5'b01111, 8, 1, 0, 0, 3'b011);

        // Over-long length clamps to the table depth
        run(4'd15, 1'b0, 3'd0, 5'd0, 8, 1, 0, 0, 3'b011);

        // Every expF flipped: error count reaches the table depth
        wr(3'd0, 5'b01010);
        wr(3'd1, 5'b11100);
        wr(3'd2, 5'b00001);
        wr(3'd3, 5'b10011);
        wr(3'd4, 5'b00100);
        wr(3'd5, 5'b11000);
        wr(3'd6, 5'b10110);
        wr(3'd7, 5'b01110);
        run(4'd8, 1'b0, 3'd0, 5'd0, 8, 0, 8, 0, 3'b011);

        chk("leftover_q0", q0.size(), 0);
        chk("leftover_q1", q1.size(), 0);
        chk("leftover_q2", q2.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
